// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multi-cycle shift-and-add multiplier sequencer:
// default widths, the ALU op encodings driven on alu_ctrl, and the FSM state type.
package mul_seq_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: low-word 32-bit multiply (MUL) done by borrowing the execute
// stage ALU for a shift-and-add loop. No datapath adder/shifter lives here;
// the ALU is requested through alu_req and its result returns combinationally
// in the same cycle. The multiplier register is shifted locally.
//
// Optional feature: define MUL_SEQ_EARLY_EXIT_EN to leave the loop as soon as
// no set multiplier bits remain (and to skip the loop entirely for op_b == 0).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; operands latched on acceptance
// ST_ADD   | ALU adds multiplicand into the accumulator (multiplier bit 1)
// ST_SHIFT | ALU shifts multiplicand left by one; multiplier shifts right
// ST_DONE  | accumulator copied to result, done pulses for one cycle
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic             alu_req,
  output logic [XLEN-1:0]  alu_src_a,
  output logic [XLEN-1:0]  alu_src_b,
  output logic [2:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_result
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_iter;

  // The final SHIFT either completes the fixed XLEN iterations or, with early
  // exit, finds no remaining multiplier bits above the one just consumed.
`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
`endif

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, register updates and ALU request decode.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    alu_req   = 1'b0;
    alu_ctrl  = ALU_ADD;
    alu_src_a = '0;
    alu_src_b = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          result_d = '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
          if (op_b == '0) begin
            state_d = ST_DONE;
          end else if (op_b[0]) begin
            state_d = ST_ADD;
          end else begin
            state_d = ST_SHIFT;
          end
`else
          if (op_b[0]) begin
            state_d = ST_ADD;
          end else begin
            state_d = ST_SHIFT;
          end
`endif
        end
      end

      ST_ADD: begin
        alu_req   = 1'b1;
        alu_ctrl  = ALU_ADD;
        alu_src_a = acc_q;
        alu_src_b = mcand_q;
        acc_d     = alu_result;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        alu_req   = 1'b1;
        alu_ctrl  = ALU_SLL;
        alu_src_a = mcand_q;
        alu_src_b = XLEN'(1);
        mcand_d   = alu_result;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        // mplier_q[1] is the bit that becomes the new LSB after this shift.
        if (last_iter) begin
          state_d = ST_DONE;
        end else if (mplier_q[1]) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        result_d = acc_q;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer. The external ALU is modelled here
// (ADD / SLL) so the sequencer sees a same-cycle combinational result.
module tb_mul_sequencer;
  import mul_seq_pkg::*;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, alu_req;
  logic [31:0] result, alu_src_a, alu_src_b, alu_result;
  logic [2:0]  alu_ctrl;

  int total = 0;
  int bad = 0;

  int          done_cyc;
  int          n_add;
  logic [2:0]  ops [1:7];
  logic [31:0] sa [1:7];
  logic [31:0] sb [1:7];
  logic [31:0] first_result;
  logic        post_busy, post_busy2;
  int          n_done;

  mul_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_req    (alu_req),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (alu_ctrl == ALU_SLL) alu_result = alu_src_a << alu_src_b;
    else                     alu_result = alu_src_a + alu_src_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one multiply, trace cycles 1..N until done (bounded), then step
  // two cycles past DONE. With inject set, start is pulsed in cycle 5 and in
  // the DONE cycle with other operands; both must be ignored.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit inject);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cyc = 0;
    n_add = 0;
    for (int i = 1; i <= 7; i++) begin
      ops[i] = 3'b111;
      sa[i] = '0;
      sb[i] = '0;
    end
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc <= 7) begin
        ops[cyc] = alu_req ? alu_ctrl : 3'b111;
        sa[cyc]  = alu_src_a;
        sb[cyc]  = alu_src_b;
      end
      if (cyc == 1) first_result = result;
      if (alu_req && alu_ctrl == ALU_ADD) n_add++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (inject && cyc == 5) begin
        start = 1'b1;
        op_a = 32'd3;
        op_b = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    if (done_cyc == 0) begin
      total++;
      bad++;
      $display("FAIL timeout: no done within 100 cycles a=%0h b=%0h", a, b);
    end
    if (inject) begin
      start = 1'b1;
      op_a = 32'd9;
      op_b = 32'd9;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    post_busy = busy;
    @(posedge clk);
    #1;
    post_busy2 = busy;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu_req", 32'(alu_req), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_src_a", alu_src_a, 32'd0);
    check("rst_src_b", alu_src_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: ALU untouched
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("idle_alu_req", 32'(alu_req), 32'd0);
      check("idle_alu_ctrl", 32'(alu_ctrl), 32'd0);
      check("idle_src_a", alu_src_a, 32'd0);
      check("idle_src_b", alu_src_b, 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // 7 x 6
    run_mul(32'd7, 32'd6, 1'b0);
    check("m76_done_cycle", 32'(done_cyc), EE ? 32'd6 : 32'd35);
    check("m76_result", result, 32'd42);
    check("m76_n_add", 32'(n_add), 32'd2);
    check("m76_op1", 32'(ops[1]), 32'(ALU_SLL));
    check("m76_op2", 32'(ops[2]), 32'(ALU_ADD));
    check("m76_op3", 32'(ops[3]), 32'(ALU_SLL));
    check("m76_op4", 32'(ops[4]), 32'(ALU_ADD));
    check("m76_op5", 32'(ops[5]), 32'(ALU_SLL));
    check("m76_c1_src_a", sa[1], 32'd7);
    check("m76_c1_src_b", sb[1], 32'd1);
    check("m76_c2_src_a", sa[2], 32'd0);
    check("m76_c2_src_b", sb[2], 32'd14);
    check("m76_c4_src_a", sa[4], 32'd14);
    check("m76_c4_src_b", sb[4], 32'd28);
    check("m76_busy_after", 32'(post_busy), 32'd0);

    // all ones: every iteration adds
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("ones_result_cleared", first_result, 32'd0);
    check("ones_done_cycle", 32'(done_cyc), 32'd65);
    check("ones_result", result, 32'h0000_0001);
    check("ones_n_add", 32'(n_add), 32'd32);

    // zero multiplier: no ADD ever issued
    run_mul(32'h1234_5678, 32'd0, 1'b0);
    check("zero_done_cycle", 32'(done_cyc), EE ? 32'd1 : 32'd33);
    check("zero_result", result, 32'd0);
    check("zero_n_add", 32'(n_add), 32'd0);

    // start while busy and in DONE ignored
    run_mul(32'd7, 32'd6, 1'b1);
    check("inj_done_cycle", 32'(done_cyc), EE ? 32'd6 : 32'd35);
    check("inj_result", result, 32'd42);
    check("inj_busy_after_done", 32'(post_busy), 32'd0);
    check("inj_busy_next", 32'(post_busy2), 32'd0);

    // reset in cycle 10 of a 7 x 6 run
    @(negedge clk);
    op_a = 32'd7;
    op_b = 32'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    check("abort_busy_before", 32'(busy), EE ? 32'd0 : 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_alu_req", 32'(alu_req), 32'd0);
    check("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("abort_result", result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort_done_count", 32'(n_done), EE ? 32'd1 : 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
